// File: rtl/tank_level_emulator.sv
// Water tank model: integrates inlet fill and outlet drain into a saturating level,
// then thermometer-encodes it onto the H/M/L probes with optional fault overrides.
module tank_level_emulator #(
  parameter int LEVEL_W   = 8,
  parameter int L_THRESH  = 32,
  parameter int M_THRESH  = 128,
  parameter int H_THRESH  = 224,
  parameter int FILL_DIV  = 4,
  parameter int DRAIN_DIV = 8,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Ve,
  input  logic               Consumo,
  input  logic               Load,
  input  logic [LEVEL_W-1:0] Load_val,
  input  logic [1:0]         Fault,
  input  logic               Clr,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] Level,
  output logic               Overflow,
  output logic               Underflow
);

  localparam logic [LEVEL_W-1:0] LP_L_TH   = LEVEL_W'(L_THRESH);
  localparam logic [LEVEL_W-1:0] LP_M_TH   = LEVEL_W'(M_THRESH);
  localparam logic [LEVEL_W-1:0] LP_H_TH   = LEVEL_W'(H_THRESH);
  localparam logic [LEVEL_W-1:0] LP_MAX    = '1;
  localparam logic [CNT_W-1:0]   LP_F_LAST = CNT_W'(FILL_DIV - 1);
  localparam logic [CNT_W-1:0]   LP_D_LAST = CNT_W'(DRAIN_DIV - 1);

  logic [CNT_W-1:0]   r_fill_cnt;
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic               r_ovf;
  logic               r_unf;
  logic               r_h;
  logic               r_m;
  logic               r_l;

  logic w_fill_step;
  logic w_drain_step;
  logic w_fill_only;
  logic w_drain_only;
  logic w_ovf_set;
  logic w_unf_set;
  logic w_raw_h;
  logic w_raw_m;
  logic w_raw_l;

  // A step fires on the cycle its prescaler wraps; Load discards it.
  assign w_fill_step  = Ve && (r_fill_cnt == LP_F_LAST);
  assign w_drain_step = Consumo && (r_drain_cnt == LP_D_LAST);
  assign w_fill_only  = !Load && w_fill_step && !w_drain_step;
  assign w_drain_only = !Load && w_drain_step && !w_fill_step;
  assign w_ovf_set    = w_fill_only && (r_level == LP_MAX);
  assign w_unf_set    = w_drain_only && (r_level == '0);

  assign w_raw_l = (r_level >= LP_L_TH);
  assign w_raw_m = (r_level >= LP_M_TH);
  assign w_raw_h = (r_level >= LP_H_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
    end else if (Load || !Ve || w_fill_step) begin
      r_fill_cnt <= '0;
    end else begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (Load || !Consumo || w_drain_step) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (Load) begin
      r_level <= Load_val;
    end else if (w_fill_only && (r_level != LP_MAX)) begin
      r_level <= r_level + 1'b1;
    end else if (w_drain_only && (r_level != '0)) begin
      r_level <= r_level - 1'b1;
    end
  end

  // Clear first so a simultaneous set condition wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (Clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= 1'b0;
      r_m <= 1'b0;
      r_l <= 1'b0;
    end else begin
      case (Fault)
        2'd1: begin
          r_h <= w_raw_h;
          r_m <= 1'b1;
          r_l <= w_raw_l;
        end
        2'd2: begin
          r_h <= 1'b1;
          r_m <= w_raw_m;
          r_l <= w_raw_l;
        end
        2'd3: begin
          r_h <= 1'b0;
          r_m <= 1'b0;
          r_l <= 1'b0;
        end
        default: begin
          r_h <= w_raw_h;
          r_m <= w_raw_m;
          r_l <= w_raw_l;
        end
      endcase
    end
  end

  assign H         = r_h;
  assign M         = r_m;
  assign L         = r_l;
  assign Level     = r_level;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule

// File: tb/tb_tank_level_emulator.sv
// Bench for tank_level_emulator: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares; directed checks cover the named scenarios.
module tb_tank_level_emulator;

  localparam int LEVEL_W   = 8;
  localparam int L_THRESH  = 32;
  localparam int M_THRESH  = 128;
  localparam int H_THRESH  = 224;
  localparam int FILL_DIV  = 4;
  localparam int DRAIN_DIV = 8;
  localparam int MAXL      = (1 << LEVEL_W) - 1;
  localparam int W         = LEVEL_W + 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               Ve = 1'b0;
  logic               Consumo = 1'b0;
  logic               Load = 1'b0;
  logic [LEVEL_W-1:0] Load_val = '0;
  logic [1:0]         Fault = 2'd0;
  logic               Clr = 1'b0;
  logic               H, M, L;
  logic [LEVEL_W-1:0] Level;
  logic               Overflow, Underflow;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  tank_level_emulator #(
    .LEVEL_W(LEVEL_W), .L_THRESH(L_THRESH), .M_THRESH(M_THRESH), .H_THRESH(H_THRESH),
    .FILL_DIV(FILL_DIV), .DRAIN_DIV(DRAIN_DIV), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Ve(Ve), .Consumo(Consumo), .Load(Load),
    .Load_val(Load_val), .Fault(Fault), .Clr(Clr), .H(H), .M(M), .L(L),
    .Level(Level), .Overflow(Overflow), .Underflow(Underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // reference model: counts consecutive request cycles, steps on every Nth one
  int m_level = 0;
  int m_fill_run = 0;
  int m_drain_run = 0;
  bit m_ovf = 0;
  bit m_unf = 0;

  always @(negedge rst_n) begin
    m_level = 0; m_fill_run = 0; m_drain_run = 0; m_ovf = 0; m_unf = 0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    bit ph, pm, pl, fs, ds, set_o, set_u;
    if (!rst_n) begin
      m_level = 0; m_fill_run = 0; m_drain_run = 0; m_ovf = 0; m_unf = 0;
      exp_q.push_back('0);
    end else begin
      pl = (m_level >= L_THRESH);
      pm = (m_level >= M_THRESH);
      ph = (m_level >= H_THRESH);
      if (Fault == 2'd1) pm = 1;
      if (Fault == 2'd2) ph = 1;
      if (Fault == 2'd3) begin ph = 0; pm = 0; pl = 0; end
      set_o = 0; set_u = 0;
      if (Load) begin
        m_level = int'(Load_val);
        m_fill_run = 0;
        m_drain_run = 0;
      end else begin
        fs = Ve && (((m_fill_run + 1) % FILL_DIV) == 0);
        ds = Consumo && (((m_drain_run + 1) % DRAIN_DIV) == 0);
        m_fill_run = Ve ? m_fill_run + 1 : 0;
        m_drain_run = Consumo ? m_drain_run + 1 : 0;
        if (fs && !ds) begin
          if (m_level == MAXL) set_o = 1; else m_level = m_level + 1;
        end else if (ds && !fs) begin
          if (m_level == 0) set_u = 1; else m_level = m_level - 1;
        end
      end
      if (Clr) begin m_ovf = 0; m_unf = 0; end
      if (set_o) m_ovf = 1;
      if (set_u) m_unf = 1;
      exp_q.push_back({ph, pm, pl, LEVEL_W'(m_level), m_ovf, m_unf});
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {H, M, L, Level, Overflow, Underflow};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual HML=%b lvl=%0d ovf=%b unf=%b expected HML=%b lvl=%0d ovf=%b unf=%b",
                 $time, a[W-1:W-3], a[W-4:2], a[1], a[0], e[W-1:W-3], e[W-4:2], e[1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load(input int val, input bit clr);
    Load = 1'b1;
    Load_val = LEVEL_W'(val);
    Clr = clr;
    cycles(1);
    Load = 1'b0;
    Clr = 1'b0;
  endtask

  task automatic load_fault(input int val, input logic [1:0] f, input int exp_hml, input string name);
    Fault = f;
    load(val, 1'b0);
    cycles(1);
    chk(name, int'({H, M, L}), exp_hml);
    chk({name, "_level"}, int'(Level), val);
  endtask

  function automatic int pick_val();
    int t;
    t = $urandom_range(0, 11);
    case (t)
      0: return 0;
      1: return 1;
      2: return 31;
      3: return 32;
      4: return 127;
      5: return 128;
      6: return 223;
      7: return 224;
      8: return 254;
      9: return 255;
      default: return $urandom_range(0, MAXL);
    endcase
  endfunction

  initial begin
    cycles(3);
    chk("reset_outputs", int'({H, M, L, Level, Overflow, Underflow}), 0);
    rst_n = 1'b1;

    // fill from empty
    Ve = 1'b1;
    cycles(3);
    chk("first_step_pending", int'(Level), 0);
    cycles(1);
    chk("first_step", int'(Level), 1);
    cycles(156);
    chk("fill_level", int'(Level), 40);
    chk("fill_hml", int'({H, M, L}), 3'b001);

    // saturation and overflow
    Ve = 1'b0;
    load(250, 1'b0);
    Ve = 1'b1;
    cycles(40);
    chk("sat_level", int'(Level), 255);
    chk("sat_ovf", int'(Overflow), 1);
    chk("sat_hml", int'({H, M, L}), 3'b111);
    Ve = 1'b0; Clr = 1'b1;
    cycles(1);
    chk("clr_ovf", int'(Overflow), 0);
    Ve = 1'b1;
    cycles(4);
    chk("clr_vs_set", int'(Overflow), 1);
    Clr = 1'b0; Ve = 1'b0;

    // simultaneous fill and drain (DRAIN_DIV is a multiple of FILL_DIV)
    load(130, 1'b1);
    Ve = 1'b1; Consumo = 1'b1;
    cycles(96);
    chk("both_level", int'(Level), 142);
    chk("both_flags", int'({Overflow, Underflow}), 0);
    chk("both_hml", int'({H, M, L}), 3'b011);
    Ve = 1'b0; Consumo = 1'b0;

    // drain to empty and underflow
    load(2, 1'b0);
    Consumo = 1'b1;
    cycles(40);
    chk("drain_level", int'(Level), 0);
    chk("drain_unf", int'(Underflow), 1);
    chk("drain_hml", int'({H, M, L}), 3'b000);
    Consumo = 1'b0;

    // fault injection
    Clr = 1'b1; cycles(1); Clr = 1'b0;
    load_fault(10, 2'd1, 3'b010, "fault1");
    load_fault(100, 2'd2, 3'b101, "fault2");
    load_fault(240, 2'd3, 3'b000, "fault3");
    Fault = 2'd0;
    cycles(1);
    chk("fault0_hml", int'({H, M, L}), 3'b111);
    chk("fault0_level", int'(Level), 240);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      Ve = ($urandom_range(0, 9) < 6);
      Consumo = ($urandom_range(0, 9) < 5);
      Load = ($urandom_range(0, 39) == 0);
      Load_val = LEVEL_W'(pick_val());
      Fault = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      Clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) < 40) begin
        Ve = 1'b1; Consumo = 1'b0;
      end
      cycles(1);
    end
    Load = 1'b0; Clr = 1'b0; Fault = 2'd0; Consumo = 1'b0;

    // asynchronous reset mid-fill
    load(50, 1'b0);
    Ve = 1'b1;
    cycles(100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'({H, M, L, Level, Overflow, Underflow}), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    chk("post_reset_hold", int'(Level), 0);
    cycles(1);
    chk("post_reset_step", int'(Level), 1);
    Ve = 1'b0;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
